ksz8851_bus_responder: RTL

Synthesizable responder for the KSZ8851-16MLL 16-bit host bus. It answers the address/data strobe sequences issued by the KSZ8851 bus master: a byte-enable-decoded register file, plus a queue-data path through RX/TX FIFOs when DMA mode is enabled. It sits on the chip side of CMD/RDn/WRn/SD and serves two purposes: a loop-back target for FPGA-level bring-up, and a cycle-accurate chip model for simulating the Ethernet I/O layers.

---
 rtl/ksz8851_bus_if.sv | 10 +
 rtl/ksz8851_bus_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ksz8851_bus_if.sv
// KSZ8851 host-bus strobes: CMD selects address (1) or data (0) phase, RDn/WRn are
// active-low strobes. The shared SD bus is carried as a separate inout port.
interface ksz8851_bus_if;
  logic ETH_CMD;
  logic ETH_RDn;
  logic ETH_WRn;

  modport master (output ETH_CMD, output ETH_RDn, output ETH_WRn);
  modport slave  (input  ETH_CMD, input  ETH_RDn, input  ETH_WRn);
endinterface

// File: rtl/ksz8851_bus_responder.sv
// Chip-side responder for the KSZ8851-16MLL 16-bit host bus: byte-enable decoded register
// file plus RX/TX queue FIFOs reached through the data phase when DMA mode is on.
module ksz8851_bus_responder #(
  parameter int unsigned FIFO_AW = 4,
  parameter logic [15:0] CHIP_ID = 16'h8872
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             ETH_RSTn,
  ksz8851_bus_if.slave     bus,
  inout  wire  [15:0]      SD,
  input  logic             rxq_wr,
  input  logic [15:0]      rxq_data,
  output logic             rxq_full,
  output logic [FIFO_AW:0] rxq_level,
  input  logic             txq_rd,
  output logic [15:0]      txq_data,
  output logic             txq_empty,
  output logic [FIFO_AW:0] txq_level,
  output logic             dma_mode,
  output logic [2:0]       err_flags,
  input  logic             err_clr
);
  localparam int unsigned        Depth     = 1 << FIFO_AW;
  localparam int unsigned        NumRegs   = 128;
  localparam logic [6:0]         IdxChipId = 7'h60;  // byte offset 0xC0
  localparam logic [6:0]         IdxDmaCtl = 7'h41;  // byte offset 0x82
  localparam logic [FIFO_AW:0]   LevelFull = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   LevelOne  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne    = FIFO_AW'(1);

  logic        wr_prev_q, rd_prev_q;
  logic [15:0] sd_hold_q;
  logic        cmd_hold_q;
  logic        addr_valid_q, addr_valid_d;
  logic [6:0]  addr_idx_q, addr_idx_d;
  logic [1:0]  byte_mask_q, byte_mask_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [2:0]  err_q, err_d, err_new;
  logic [15:0] regs_q [NumRegs];

  logic [15:0]        rx_mem [Depth];
  logic [15:0]        tx_mem [Depth];
  logic [FIFO_AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q, tx_wr_ptr_q, tx_rd_ptr_q;
  logic [FIFO_AW:0]   rx_level_q, tx_level_q;

  logic        wr_commit, rd_fall, data_wr, reg_wr;
  logic        tx_push_req, tx_push, tx_pop, tx_full;
  logic        rx_pop_req, rx_pop, rx_push, rx_empty;
  logic        be_legal, lane;
  logic [1:0]  be_mask;
  logic [15:0] reg_wdata, rx_pop_word;

  assign wr_commit   = bus.ETH_WRn & ~wr_prev_q;
  assign rd_fall     = ~bus.ETH_RDn & rd_prev_q & ~bus.ETH_CMD;
  assign data_wr     = wr_commit & ~cmd_hold_q & addr_valid_q;
  assign reg_wr      = data_wr & ~dma_mode;
  assign tx_push_req = data_wr & dma_mode;
  assign rx_pop_req  = rd_fall & dma_mode;

  assign dma_mode  = regs_q[IdxDmaCtl][3];
  assign err_flags = err_q;

  // Driven only after RDn was already low at a clock edge, so rd_data is loaded first.
  assign SD = (~bus.ETH_RDn & ~bus.ETH_CMD & ~rd_prev_q) ? rd_data_q : {16{1'bz}};

  // A simultaneous push and pop always both happen, even at the full/empty boundary.
  assign rx_empty  = (rx_level_q == '0);
  assign rxq_full  = (rx_level_q == LevelFull);
  assign rxq_level = rx_level_q;
  assign rx_pop    = ETH_RSTn & rx_pop_req & (~rx_empty | rxq_wr);
  assign rx_push   = ETH_RSTn & rxq_wr & (~rxq_full | rx_pop_req);
  assign rx_pop_word = rx_empty ? rxq_data : rx_mem[rx_rd_ptr_q];

  assign txq_empty = (tx_level_q == '0);
  assign tx_full   = (tx_level_q == LevelFull);
  assign txq_level = tx_level_q;
  assign tx_pop    = ETH_RSTn & txq_rd & (~txq_empty | tx_push_req);
  assign tx_push   = ETH_RSTn & tx_push_req & (~tx_full | txq_rd);
  assign txq_data  = (txq_empty & tx_push_req) ? sd_hold_q : tx_mem[tx_rd_ptr_q];

  always_comb begin
    be_legal = 1'b1;
    lane     = 1'b0;
    be_mask  = 2'b11;
    case (sd_hold_q[15:12])
      4'b0011: begin lane = 1'b0; be_mask = 2'b11; end
      4'b1100: begin lane = 1'b1; be_mask = 2'b11; end
      4'b0001: begin lane = 1'b0; be_mask = 2'b01; end
      4'b0010: begin lane = 1'b0; be_mask = 2'b10; end
      4'b0100: begin lane = 1'b1; be_mask = 2'b01; end
      4'b1000: begin lane = 1'b1; be_mask = 2'b10; end
      default: be_legal = 1'b0;
    endcase
  end

  always_comb begin
    addr_valid_d = addr_valid_q;
    addr_idx_d   = addr_idx_q;
    byte_mask_d  = byte_mask_q;
    if (wr_commit && cmd_hold_q) begin
      addr_valid_d = be_legal;
      addr_idx_d   = {sd_hold_q[7:2], lane};
      byte_mask_d  = be_mask;
    end

    rd_data_d = rd_data_q;
    if (rd_fall) begin
      if (dma_mode) begin
        rd_data_d = rx_pop ? rx_pop_word : 16'h0000;
      end else if (addr_valid_q) begin
        rd_data_d = regs_q[addr_idx_q];
      end else begin
        rd_data_d = 16'h0000;
      end
    end

    reg_wdata = regs_q[addr_idx_q];
    if (byte_mask_q[0]) reg_wdata[7:0]  = sd_hold_q[7:0];
    if (byte_mask_q[1]) reg_wdata[15:8] = sd_hold_q[15:8];

    err_new[0] = wr_commit & cmd_hold_q & ~be_legal;
    err_new[1] = rx_pop_req & ~rx_pop;
    err_new[2] = tx_push_req & ~tx_push;
    err_d      = (err_clr ? 3'b000 : err_q) | err_new;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_prev_q    <= 1'b1;
      rd_prev_q    <= 1'b1;
      sd_hold_q    <= '0;
      cmd_hold_q   <= 1'b0;
      addr_valid_q <= 1'b0;
      addr_idx_q   <= '0;
      byte_mask_q  <= '0;
      rd_data_q    <= '0;
      err_q        <= '0;
    end else if (!ETH_RSTn) begin
      wr_prev_q    <= 1'b1;
      rd_prev_q    <= 1'b1;
      sd_hold_q    <= '0;
      cmd_hold_q   <= 1'b0;
      addr_valid_q <= 1'b0;
      addr_idx_q   <= '0;
      byte_mask_q  <= '0;
      rd_data_q    <= '0;
      err_q        <= '0;
    end else begin
      wr_prev_q    <= bus.ETH_WRn;
      rd_prev_q    <= bus.ETH_RDn;
      if (!bus.ETH_WRn) begin
        sd_hold_q  <= SD;
        cmd_hold_q <= bus.ETH_CMD;
      end
      addr_valid_q <= addr_valid_d;
      addr_idx_q   <= addr_idx_d;
      byte_mask_q  <= byte_mask_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (7'(i) == IdxChipId) ? CHIP_ID : 16'h0000;
      end
    end else if (!ETH_RSTn) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (7'(i) == IdxChipId) ? CHIP_ID : 16'h0000;
      end
    end else if (reg_wr) begin
      regs_q[addr_idx_q] <= reg_wdata;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
    end else if (!ETH_RSTn) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PtrOne;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PtrOne;
      if (rx_push && !rx_pop) rx_level_q <= rx_level_q + LevelOne;
      else if (!rx_push && rx_pop) rx_level_q <= rx_level_q - LevelOne;
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PtrOne;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PtrOne;
      if (tx_push && !tx_pop) tx_level_q <= tx_level_q + LevelOne;
      else if (!tx_push && tx_pop) tx_level_q <= tx_level_q - LevelOne;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rxq_data;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= sd_hold_q;
  end

endmodule
